serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// A single full-subtractor cell and a borrow flop do all the arithmetic.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic             br_msb_in;
    logic [CW-1:0]    cnt;

    logic a0;
    logic b0;
    logic d;
    logic br_next;

    always_comb begin
        a0      = a_sr[0];
        b0      = b_sr[0];
        d       = a0 ^ b0 ^ br;
        br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            overflow  <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            d_sr      <= '0;
            br        <= 1'b0;
            br_msb_in <= 1'b0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    d_sr <= {d, d_sr[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    // borrow entering the sign bit, kept for signed overflow
                    if (cnt == PENULT) begin
                        br_msb_in <= br_next;
                    end
                    if (cnt == LAST) begin
                        diff     <= {d, d_sr[WIDTH-1:1]};
                        bout     <= br_next;
                        overflow <= br_next ^ br_msb_in;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks for serial_subtractor (WIDTH=8 and WIDTH=4).
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       overflow;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;
    logic       overflow4;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout),
        .overflow (overflow)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start4),
        .a        (a4),
        .b        (b4),
        .bin      (bin4),
        .busy     (busy4),
        .done     (done4),
        .diff     (diff4),
        .bout     (bout4),
        .overflow (overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_done(output int bcyc, output bit ok);
        bcyc = 0;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tbin, output int bcyc, output bit ok);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bcyc, ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        #3;
        total++;
        if ({busy, done, diff, bout, overflow} !== 11'd0) begin
            bad++;
            $display("FAIL reset: got %b want 0", {busy, done, diff, bout, overflow});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_op(input string name, input logic [7:0] ta,
                           input logic [7:0] tb_, input logic tbin,
                           input logic [7:0] ed, input logic eb, input logic eo);
        int bcyc;
        bit ok;
        run8(ta, tb_, tbin, bcyc, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout: done never rose", name);
        end
        total++;
        if (bcyc !== 8) begin
            bad++;
            $display("FAIL %s_busy: busy cycles=%0d want 8", name, bcyc);
        end
        total++;
        if ({diff, bout, overflow} !== {ed, eb, eo}) begin
            bad++;
            $display("FAIL %s: diff=%h bout=%b ov=%b want diff=%h bout=%b ov=%b",
                     name, diff, bout, overflow, ed, eb, eo);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s_strobe: done=%b want 0 after one cycle", name, done);
        end
        total++;
        if ({diff, bout, overflow} !== {ed, eb, eo}) begin
            bad++;
            $display("FAIL %s_hold: diff=%h want %h", name, diff, ed);
        end
    endtask

    task automatic test_ignore();
        int bcyc;
        bit ok;
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h33; b = 8'hC4;
        wait_done(bcyc, ok);
        total++;
        if (!ok || {diff, bout, overflow} !== {8'h0F, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ignore: ok=%b diff=%h bout=%b ov=%b want 0f 0 0",
                     ok, diff, bout, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bcyc;
        bit ok;
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(bcyc, ok);
        total++;
        if (!ok || diff !== 8'h02) begin
            bad++;
            $display("FAIL b2b_first: ok=%b diff=%h want 02", ok, diff);
        end
        a = 8'h03; b = 8'h05;
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_nobubble: busy/done=%b want 10", {busy, done});
        end
        start = 1'b0;
        wait_done(bcyc, ok);
        total++;
        if (!ok || {diff, bout, overflow} !== {8'hFE, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_second: ok=%b diff=%h bout=%b ov=%b want fe 1 0",
                     ok, diff, bout, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, diff, bout, overflow} !== 11'd0) begin
            bad++;
            $display("FAIL reset_mid: got %b want 0", {busy, done, diff, bout, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle: busy=%b want 0", busy);
        end
        test_op("after_reset", 8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);
    endtask

    task automatic test_sweep4();
        int r;
        int sa;
        int sb;
        int sr;
        bit ok;
        logic [3:0] ed;
        logic eb;
        logic eo;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = ic[0]; start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    ok = 1'b0;
                    for (int k = 0; k < 20; k++) begin
                        if (done4) begin
                            ok = 1'b1;
                            break;
                        end
                        @(negedge clk);
                    end
                    r  = ia - ib - ic;
                    ed = 4'(r);
                    eb = (r < 0);
                    sa = (ia > 7) ? ia - 16 : ia;
                    sb = (ib > 7) ? ib - 16 : ib;
                    sr = sa - sb - ic;
                    eo = (sr < -8) || (sr > 7);
                    total++;
                    if (!ok || {diff4, bout4, overflow4} !== {ed, eb, eo}) begin
                        bad++;
                        $display("FAIL sweep4 a=%0d b=%0d bin=%0d: ok=%b diff=%h bout=%b ov=%b want %h %b %b",
                                 ia, ib, ic, ok, diff4, bout4, overflow4, ed, eb, eo);
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_op("sub_basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        test_op("sub_neg",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        test_op("ov_pos",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        test_op("ov_both",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        test_op("zero_bin",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        test_op("eq_bin",    8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0);
        test_op("all_zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_sweep4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
